// File: rtl/ula_full_pkg.sv
// Shared constants for the ULA scheduler, the ULA itself and its bench.
// Contents: FSM state encoding, ULA opcode names, flag bit indices, MODE_MAX.
package ula_full_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

    // rsp_flags = {carry, negative, zero, saturate, overflow}
    localparam int FLG_OVF   = 0;
    localparam int FLG_SAT   = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_CARRY = 4;

    // Numeric modes: 0 unsigned wrap, 1 signed wrap, 2 unsigned saturate,
    // 3 signed saturate, 4 signed fixed-point saturate (MUL rescaled by FRAC).
    localparam logic [2:0] MODE_MAX = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

endpackage

// File: rtl/ula_full_behavioral.sv
// Combinational ULA: add/sub/and/or/xor/not/shl/mul with wrap or saturate.
// Ports: op_a, op_b operands; op_sel operation; num_mode numeric mode;
// result WIDTH bits; flags {carry,negative,zero,saturate,overflow}.
// Arithmetic is done on an exact wide value, then range-checked against the
// unsigned or signed WIDTH-bit range to derive overflow and saturation.
import ula_full_pkg::*;

module ula_full_behavioral #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    input  logic [2:0]       num_mode,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int EW = 2*WIDTH + 2;
    localparam logic signed [EW-1:0] UMAX = EW'((2**WIDTH) - 1);
    localparam logic signed [EW-1:0] SMAX = EW'((2**(WIDTH-1)) - 1);
    localparam logic signed [EW-1:0] SMIN = EW'(-(2**(WIDTH-1)));

    logic                   sgn, sat, arith, carry, ovf;
    logic signed [EW-1:0]   ax, bx, ex, lo, hi;
    logic        [WIDTH:0]  raw_add, raw_sub;
    logic        [WIDTH-1:0] res;

    always_comb begin
        sgn     = num_mode inside {3'd1, 3'd3, 3'd4};
        sat     = (num_mode >= 3'd2);
        ax      = {{(EW-WIDTH){sgn & op_a[WIDTH-1]}}, op_a};
        bx      = {{(EW-WIDTH){sgn & op_b[WIDTH-1]}}, op_b};
        lo      = sgn ? SMIN : '0;
        hi      = sgn ? SMAX : UMAX;
        raw_add = {1'b0, op_a} + {1'b0, op_b};
        raw_sub = {1'b0, op_a} - {1'b0, op_b};
        ex      = '0;
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        arith   = 1'b1;
        case (op_sel)
            OP_ADD: begin ex = ax + bx;  carry = raw_add[WIDTH]; end
            OP_SUB: begin ex = ax - bx;  carry = raw_sub[WIDTH]; end
            OP_AND: begin res = op_a & op_b; arith = 1'b0; end
            OP_OR:  begin res = op_a | op_b; arith = 1'b0; end
            OP_XOR: begin res = op_a ^ op_b; arith = 1'b0; end
            OP_NOT: begin res = ~op_a;       arith = 1'b0; end
            OP_SHL: begin ex = ax <<< 1; carry = op_a[WIDTH-1]; end
            default: begin
                // Fixed-point mode rescales the product back to FRAC bits.
                if (num_mode == 3'd4) ex = (ax * bx) >>> FRAC;
                else                  ex = ax * bx;
            end
        endcase
        if (arith) begin
            ovf = (ex < lo) || (ex > hi);
            if (ovf && sat) res = (ex < lo) ? lo[WIDTH-1:0] : hi[WIDTH-1:0];
            else            res = ex[WIDTH-1:0];
        end
        result           = res;
        flags            = '0;
        flags[FLG_CARRY] = carry;
        flags[FLG_NEG]   = res[WIDTH-1];
        flags[FLG_ZERO]  = (res == '0);
        flags[FLG_SAT]   = ovf & sat;
        flags[FLG_OVF]   = ovf;
    end

endmodule

// File: rtl/ula_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports: req[1:0] requests, rr_last last-served index (state owned by the
// parent), en grant enable, gnt[1:0] one-hot grant (zero when !en).
import ula_full_pkg::*;

module ula_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // On a tie the requester that was not served last wins.
            if (req == 2'b11) gnt = rr_last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

endmodule

// File: rtl/ula_full_sched.sv
// Two-requester round-robin scheduler around one ula_full_behavioral.
// Ports: per master X in {0,1}: mX_req_valid/ready, mX_op_a/op_b/op_sel/
// num_mode request payload, mX_rsp_valid/ready response handshake; shared
// rsp_result, rsp_flags, rsp_err; busy (state != IDLE).
// Optional ULA_FULL_SCHED_STATS_EN adds stat_clr, stat_ops0, stat_ops1,
// stat_ovsat completion counters (saturating 16-bit).
// Flow: IDLE (accept) -> EXEC (capture ULA output) -> RESP (hold until ready).
import ula_full_pkg::*;

module ula_full_sched #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_req_valid,
    output logic             m0_req_ready,
    input  logic [WIDTH-1:0] m0_op_a,
    input  logic [WIDTH-1:0] m0_op_b,
    input  logic [2:0]       m0_op_sel,
    input  logic [2:0]       m0_num_mode,
    output logic             m0_rsp_valid,
    input  logic             m0_rsp_ready,
    input  logic             m1_req_valid,
    output logic             m1_req_ready,
    input  logic [WIDTH-1:0] m1_op_a,
    input  logic [WIDTH-1:0] m1_op_b,
    input  logic [2:0]       m1_op_sel,
    input  logic [2:0]       m1_num_mode,
    output logic             m1_rsp_valid,
    input  logic             m1_rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_err,
`ifdef ULA_FULL_SCHED_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_ops0,
    output logic [15:0]      stat_ops1,
    output logic [15:0]      stat_ovsat,
`endif
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] op_a_q, op_b_q, ula_result;
    logic [2:0]       op_sel_q, mode_q;
    logic [4:0]       ula_flags;
    logic             owner_q, rr_last, rsp_hs;
    logic [1:0]       gnt;

    ula_rr_arb2 u_arb (
        .req     ({m1_req_valid, m0_req_valid}),
        .rr_last (rr_last),
        .en      (state == IDLE),
        .gnt     (gnt)
    );

    assign m0_req_ready = gnt[0];
    assign m1_req_ready = gnt[1];
    assign rsp_hs = (m0_rsp_valid & m0_rsp_ready) | (m1_rsp_valid & m1_rsp_ready);

    ula_full_behavioral #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ula (
        .op_a     (op_a_q),
        .op_b     (op_b_q),
        .op_sel   (op_sel_q),
        .num_mode (mode_q),
        .result   (ula_result),
        .flags    (ula_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            mode_q       <= '0;
            owner_q      <= 1'b0;
            rr_last      <= 1'b1;   // m0 wins the first tie
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_err      <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    op_a_q   <= gnt[1] ? m1_op_a     : m0_op_a;
                    op_b_q   <= gnt[1] ? m1_op_b     : m0_op_b;
                    op_sel_q <= gnt[1] ? m1_op_sel   : m0_op_sel;
                    mode_q   <= gnt[1] ? m1_num_mode : m0_num_mode;
                    owner_q  <= gnt[1];
                    rr_last  <= gnt[1];
                    busy     <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    // Illegal mode: report an error with zero payload, same latency.
                    if (mode_q > MODE_MAX) begin
                        rsp_result <= '0;
                        rsp_flags  <= '0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= ula_result;
                        rsp_flags  <= ula_flags;
                        rsp_err    <= 1'b0;
                    end
                    m0_rsp_valid <= ~owner_q;
                    m1_rsp_valid <= owner_q;
                    state        <= RESP;
                end
                RESP: if (rsp_hs) begin
                    m0_rsp_valid <= 1'b0;
                    m1_rsp_valid <= 1'b0;
                    rsp_err      <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ULA_FULL_SCHED_STATS_EN
    // Counted on the response handshake; illegal ops carry zero flags so
    // they never reach the overflow/saturate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops0  <= '0;
            stat_ops1  <= '0;
            stat_ovsat <= '0;
        end else if (stat_clr) begin
            stat_ops0  <= '0;
            stat_ops1  <= '0;
            stat_ovsat <= '0;
        end else if (rsp_hs) begin
            if (owner_q) begin
                if (stat_ops1 != 16'hFFFF) stat_ops1 <= stat_ops1 + 16'd1;
            end else begin
                if (stat_ops0 != 16'hFFFF) stat_ops0 <= stat_ops0 + 16'd1;
            end
            if ((rsp_flags[FLG_OVF] | rsp_flags[FLG_SAT]) && stat_ovsat != 16'hFFFF)
                stat_ovsat <= stat_ovsat + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ula_full_sched.sv
// Bench for ula_full_sched: scoreboard of expected responses pushed at
// request accept and checked at response handshake, plus scenario tasks.
// Build with ULA_FULL_SCHED_STATS_EN defined to also cover the counters.
module tb_ula_full_sched;
    import ula_full_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
    logic       m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
    logic [7:0] m0_op_a, m0_op_b, m1_op_a, m1_op_b, rsp_result;
    logic [2:0] m0_op_sel, m0_num_mode, m1_op_sel, m1_num_mode;
    logic [4:0] rsp_flags;
    logic       rsp_err, busy;
`ifdef ULA_FULL_SCHED_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_ops0, stat_ops1, stat_ovsat;
`endif

    ula_full_sched #(.WIDTH(8), .FRAC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_op_a(m0_op_a), .m0_op_b(m0_op_b), .m0_op_sel(m0_op_sel), .m0_num_mode(m0_num_mode),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_op_a(m1_op_a), .m1_op_b(m1_op_b), .m1_op_sel(m1_op_sel), .m1_num_mode(m1_num_mode),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
`ifdef ULA_FULL_SCHED_STATS_EN
        .stat_clr(stat_clr), .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_ovsat(stat_ovsat),
`endif
        .busy(busy)
    );

    typedef struct {
        logic       owner;
        logic [7:0] res;
        logic [4:0] flg;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference ULA written with plain integer arithmetic.
    function automatic exp_t ref_op(input logic ow, input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] sel, input logic [2:0] mode);
        exp_t e;
        int sa, sbv, ex, lo, hi;
        bit sgn, sat, arith, c, v;
        logic [7:0] r;
        e.owner = ow; e.err = 1'b0; r = 8'h00; c = 0; v = 0; arith = 1; ex = 0;
        if (mode > 3'd4) begin
            e.res = 8'h00; e.flg = 5'h00; e.err = 1'b1;
            return e;
        end
        sgn = (mode == 3'd1) || (mode == 3'd3) || (mode == 3'd4);
        sat = (mode >= 3'd2);
        if (sgn) begin sa = int'($signed(a)); sbv = int'($signed(b)); end
        else     begin sa = int'(a);          sbv = int'(b);          end
        case (sel)
            3'd0: begin ex = sa + sbv; c = (int'(a) + int'(b)) > 255; end
            3'd1: begin ex = sa - sbv; c = (a < b); end
            3'd2: begin r = a & b; arith = 0; end
            3'd3: begin r = a | b; arith = 0; end
            3'd4: begin r = a ^ b; arith = 0; end
            3'd5: begin r = ~a;    arith = 0; end
            3'd6: begin ex = sa * 2; c = a[7]; end
            default: begin ex = sa * sbv; if (mode == 3'd4) ex = ex >>> 4; end
        endcase
        if (arith) begin
            lo = sgn ? -128 : 0;
            hi = sgn ? 127 : 255;
            v = (ex < lo) || (ex > hi);
            if (v && sat) r = (ex < lo) ? 8'(lo) : 8'(hi);
            else          r = 8'(ex);
        end
        e.res = r;
        e.flg = {c, r[7], (r == 8'h00), v & sat, v};
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if ((m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready)) begin
                n_cmp++;
                if ((m0_req_ready && m1_req_ready) !== 1'b0) begin
                    n_bad++;
                    $display("FAIL grant_onehot: got ready0=%b ready1=%b, expected not both", m0_req_ready, m1_req_ready);
                end
                if (m1_req_valid && m1_req_ready)
                    sb.push_back(ref_op(1'b1, m1_op_a, m1_op_b, m1_op_sel, m1_num_mode));
                else
                    sb.push_back(ref_op(1'b0, m0_op_a, m0_op_b, m0_op_sel, m0_num_mode));
            end
            if ((m0_rsp_valid && m0_rsp_ready) || (m1_rsp_valid && m1_rsp_ready)) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: got response with no request outstanding, expected none");
                end else begin
                    e = sb.pop_front();
                    if ({m1_rsp_valid, m0_rsp_valid, rsp_result, rsp_flags, rsp_err} !==
                        {e.owner, ~e.owner, e.res, e.flg, e.err}) begin
                        n_bad++;
                        $display("FAIL response: got v1=%b v0=%b res=%h flg=%b err=%b, expected owner=%0d res=%h flg=%b err=%b",
                                 m1_rsp_valid, m0_rsp_valid, rsp_result, rsp_flags, rsp_err, e.owner, e.res, e.flg, e.err);
                    end
                end
            end
        end
    end

    task automatic send(input logic ch, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic [2:0] mode);
        bit ok = 0;
        if (ch) begin m1_op_a = a; m1_op_b = b; m1_op_sel = sel; m1_num_mode = mode; m1_req_valid = 1; end
        else    begin m0_op_a = a; m0_op_b = b; m0_op_sel = sel; m0_num_mode = mode; m0_req_valid = 1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ch ? m1_req_ready : m0_req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no ready on m%0d in 60 cycles, expected accept", ch);
        end
        @(posedge clk); #1;
        if (ch) m1_req_valid = 0; else m0_req_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d, expected idle", busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        n_cmp++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, busy, rsp_err, rsp_result, rsp_flags} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b busy=%b err=%b res=%h flg=%b, expected all 0",
                     m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, busy, rsp_err, rsp_result, rsp_flags);
        end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_tie();
        int who[3];
        int at[3];
        int cnt = 0;
        m0_op_a = 8'd10; m0_op_b = 8'd20; m0_op_sel = OP_ADD; m0_num_mode = 3'd0;
        m1_op_a = 8'd50; m1_op_b = 8'd60; m1_op_sel = OP_SUB; m1_num_mode = 3'd1;
        m0_req_valid = 1; m1_req_valid = 1;
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            @(negedge clk);
            if (m0_req_ready)      begin who[cnt] = 0; at[cnt] = i; cnt++; end
            else if (m1_req_ready) begin who[cnt] = 1; at[cnt] = i; cnt++; end
        end
        @(posedge clk); #1 m0_req_valid = 0; m1_req_valid = 0;
        n_cmp++;
        if (cnt != 3 || who[0] != 0 || who[1] != 1 || who[2] != 0) begin
            n_bad++;
            $display("FAIL tie_order: got %0d grants %0d,%0d,%0d, expected 0,1,0", cnt, who[0], who[1], who[2]);
        end
        n_cmp++;
        if (cnt == 3 && (at[1] - at[0] != 3 || at[2] - at[1] != 3)) begin
            n_bad++;
            $display("FAIL tie_spacing: got gaps %0d,%0d cycles, expected 3,3", at[1] - at[0], at[2] - at[1]);
        end
        wait_idle();
    endtask

    task automatic test_single();
        exp_t e;
        e = ref_op(1'b0, 8'h03, 8'h05, OP_ADD, 3'd0);
        send(1'b0, 8'h03, 8'h05, OP_ADD, 3'd0);
        @(negedge clk);
        n_cmp++;
        if (m0_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: got m0_rsp_valid=%b one cycle after accept, expected 0", m0_rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({m0_rsp_valid, m1_rsp_valid, rsp_result, rsp_flags} !== {1'b1, 1'b0, e.res, e.flg}) begin
            n_bad++;
            $display("FAIL single_resp: got v0=%b v1=%b res=%h flg=%b, expected 1 0 %h %b",
                     m0_rsp_valid, m1_rsp_valid, rsp_result, rsp_flags, e.res, e.flg);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit ok = 0;
        e = ref_op(1'b1, 8'h90, 8'h30, OP_ADD, 3'd3);
        m1_rsp_ready = 0;
        send(1'b1, 8'h90, 8'h30, OP_ADD, 3'd3);
        m0_op_a = 8'h11; m0_op_b = 8'h22; m0_op_sel = OP_OR; m0_num_mode = 3'd0; m0_req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_rsp_valid) begin ok = 1; break; end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (!ok || {rsp_result, busy, m0_req_ready, m1_rsp_valid} !== {e.res, 1'b1, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got res=%h busy=%b m0_ready=%b v1=%b, expected %h 1 0 1",
                         i, rsp_result, busy, m0_req_ready, m1_rsp_valid, e.res);
            end
        end
        @(posedge clk); #1 m1_rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m0_req_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: got m0_ready=%b busy=%b after handshake, expected 1 0", m0_req_ready, busy);
        end
        @(posedge clk); #1 m0_req_valid = 0;
        wait_idle();
    endtask

    task automatic test_illegal();
        send(1'b0, 8'hFF, 8'h01, OP_ADD, 3'd6);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m0_rsp_valid, rsp_err, rsp_result, rsp_flags} !== {1'b1, 1'b1, 8'h00, 5'h00}) begin
            n_bad++;
            $display("FAIL illegal_resp: got v0=%b err=%b res=%h flg=%b, expected 1 1 00 00000",
                     m0_rsp_valid, rsp_err, rsp_result, rsp_flags);
        end
        @(negedge clk);
        n_cmp++;
        if ({m0_rsp_valid, rsp_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL illegal_clear: got v0=%b err=%b after handshake, expected 0 0", m0_rsp_valid, rsp_err);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            logic [2:0] md;
            md = 3'($urandom_range(0, 5));
            if (md == 3'd5) md = 3'd7;
            send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), md);
        end
        // Directed corner cases: saturation both ways and fixed-point multiply.
        send(1'b0, 8'h7F, 8'h01, OP_ADD, 3'd3);
        send(1'b1, 8'h80, 8'h01, OP_SUB, 3'd3);
        send(1'b0, 8'h03, 8'h05, OP_SUB, 3'd2);
        send(1'b1, 8'h10, 8'h20, OP_MUL, 3'd4);
        send(1'b0, 8'hF0, 8'h02, OP_MUL, 3'd2);
        wait_idle();
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        send(1'b0, 8'h10, 8'h20, OP_ADD, 3'd0);
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, busy, rsp_err, rsp_result, rsp_flags} !== 19'h0) begin
            n_bad++;
            $display("FAIL abort_outputs: got vld=%b%b busy=%b res=%h flg=%b, expected all 0",
                     m0_rsp_valid, m1_rsp_valid, busy, rsp_result, rsp_flags);
        end
        sb.delete();
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m0_rsp_valid || m1_rsp_valid || busy) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL abort_quiet: got response or busy after reset release, expected none");
        end
        @(posedge clk); #1;
        m0_op_a = 8'h01; m0_op_b = 8'h02; m0_op_sel = OP_XOR; m0_num_mode = 3'd0;
        m1_op_a = 8'h03; m1_op_b = 8'h04; m1_op_sel = OP_AND; m1_num_mode = 3'd0;
        m0_req_valid = 1; m1_req_valid = 1;
        @(negedge clk);
        n_cmp++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_tie: got ready0=%b ready1=%b, expected 1 0", m0_req_ready, m1_req_ready);
        end
        @(posedge clk); #1 m0_req_valid = 0;
        send(1'b1, 8'h03, 8'h04, OP_AND, 3'd0);
        wait_idle();
    endtask

`ifdef ULA_FULL_SCHED_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1 stat_clr = 1;
        @(posedge clk); #1 stat_clr = 0;
        send(1'b0, 8'h7F, 8'h01, OP_ADD, 3'd1);
        send(1'b0, 8'h01, 8'h01, OP_ADD, 3'd0);
        send(1'b0, 8'h02, 8'h03, OP_AND, 3'd0);
        send(1'b1, 8'h05, 8'h03, OP_SUB, 3'd0);
        send(1'b1, 8'h04, 8'h01, OP_OR,  3'd0);
        wait_idle();
        @(negedge clk);
        n_cmp++;
        if ({stat_ops0, stat_ops1, stat_ovsat} !== {16'd3, 16'd2, 16'd1}) begin
            n_bad++;
            $display("FAIL stats_count: got ops0=%0d ops1=%0d ovsat=%0d, expected 3 2 1", stat_ops0, stat_ops1, stat_ovsat);
        end
        @(posedge clk); #1 stat_clr = 1;
        @(posedge clk); #1 stat_clr = 0;
        @(negedge clk);
        n_cmp++;
        if ({stat_ops0, stat_ops1, stat_ovsat} !== 48'h0) begin
            n_bad++;
            $display("FAIL stats_clear: got ops0=%0d ops1=%0d ovsat=%0d, expected 0 0 0", stat_ops0, stat_ops1, stat_ovsat);
        end
    endtask
`endif

    initial begin
        m0_req_valid = 0; m1_req_valid = 0; m0_rsp_ready = 1; m1_rsp_ready = 1;
        m0_op_a = 0; m0_op_b = 0; m0_op_sel = 0; m0_num_mode = 0;
        m1_op_a = 0; m1_op_b = 0; m1_op_sel = 0; m1_num_mode = 0;
`ifdef ULA_FULL_SCHED_STATS_EN
        stat_clr = 0;
`endif
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
`ifdef ULA_FULL_SCHED_STATS_EN
        test_stats();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d responses outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
